run_length_decoder: RTL
=======================

Name: run_length_decoder

Overview:
- Receive end of the run-length encoded character stream produced by the encoder FSM.
- Accepts 8-bit encoded words {tag, data[6:0]} under a valid/ready handshake and expands them back into a plain 7-bit character stream under a second valid/ready handshake.
- Sits between the encoded-stream source (link/FIFO) and the character consumer.

Parameters:
- DATA_W, 7: character width. The encoded word is DATA_W+1 bits, and the run count uses the full DATA_W+1 bits.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- inValid  in  1  encoded word present
- inTag  in  1  encoded word bit 7; 1 = run marker
- inData  in  DATA_W  encoded word bits 6:0
- inReady  out  1  decoder accepts word this cycle
- outValid  out  1  decoded character present
- outData  out  DATA_W  decoded character
- outReady  in  1  consumer accepts character this cycle
- err  out  1  one-cycle error pulse; tied 0 unless RLD_ERR_CHECK_EN

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, inReady=0, outValid=0, outData=0, err=0, runChar=0, runCnt=0.
- Handshake:
  - Input transfer occurs when inValid && inReady.
  - Output transfer occurs when outValid && outReady.
  - While outValid=1 && outReady=0, outData is held stable.
- Protocol:
  - A word with tag=0 is a literal, emitted once.
  - A word with tag=1 is a run header; data is the run character.
  - The next accepted word is the run count N = {inTag, inData}, unsigned, range 0..255.
- States: IDLE, READ_SYM, GET_COUNT, EMIT_RUN.
- IDLE:
  - inReady=0.
  - Unconditionally moves to READ_SYM on the first clock after reset_n deasserts.
- READ_SYM:
  - inReady = !outValid || outReady.
  - On accepting a literal: outData<=inData and outValid<=1 on the next edge, so latency is 1 cycle. State stays READ_SYM. Literals can stream at one per cycle.
  - On accepting a header: runChar<=inData, then move to GET_COUNT. outValid may still drain a prior literal.
- GET_COUNT:
  - inReady = !outValid || outReady.
  - On accept with N=0: no output; return to READ_SYM.
  - On accept with N>0: runCnt<=N, outData<=runChar, outValid<=1, move to EMIT_RUN.
- EMIT_RUN:
  - inReady=0 and outValid=1.
  - Each output transfer decrements runCnt.
  - A transfer with runCnt==1 ends the run: outValid<=0, move to READ_SYM.
  - A run of N delivers exactly N characters, back-to-back when outReady stays high.
- Boundary conditions:
  - N=255: exactly 255 characters emitted; runCnt never wraps.
  - A header immediately followed by a header-tagged word in GET_COUNT: the word is interpreted as a count (tag bit = count MSB), never as a new header.
  - inValid with inReady=0: the word is not consumed. The source must hold it.
  - reset_n asserted mid-run: immediately outValid=0, inReady=0, state=IDLE. The remaining run is discarded.
- No internal FIFO beyond the single output register.

Optional Feature:
- Macro: RLD_ERR_CHECK_EN.
- Defined:
  - A literal or run character with value < 32 (non-printable) is consumed but not emitted.
  - A count N=0 is flagged.
  - Each such event raises err=1 for exactly one cycle, on the edge after the offending input transfer.
  - State transitions are unchanged. A bad header character still consumes its count word, then returns to READ_SYM without emitting.
- Undefined:
  - err tied to 0.
  - All characters are emitted regardless of value.
  - N=0 is silently dropped.

Test Plan:
1. Literal: after reset, inTag=0, inData=0x41, outReady=1 -> outValid=1 with outData=0x41 one cycle after transfer, for exactly one cycle. IDLE lasts exactly one cycle after reset release.
2. Run: header {1,0x42} then count 0x05, outReady=1 -> five consecutive cycles outData=0x42; inReady=0 throughout, then inReady=1.
3. Backpressure: run {1,0x43} count 6, outReady low for 3 cycles after the 2nd character -> outData held at 0x43, total transfers exactly 6.
4. Boundary counts:
   - count 0x00 -> no outValid.
   - count 0xFF -> exactly 255 characters.
   - header followed by word {1,0x02} -> run of 130.
5. Reset mid-run: run count 10, reset_n low after 2 transfers -> outValid=0 asynchronously; after release, one IDLE cycle, then inReady=1 and the next literal decodes normally.
6. RLD_ERR_CHECK_EN: literal 0x10 -> no output, err pulse of 1 cycle; count 0 -> err pulse. Without the macro: 0x10 emitted, err stays 0.

Source files
------------

// File: rtl/run_length_decoder.sv
// Run-length decoder: expands {tag,data} words (literal, or header + count) into a plain character stream.
// Optional macro RLD_ERR_CHECK_EN: drop non-printable characters and flag them and zero counts on err.
module run_length_decoder #(
  parameter int DATA_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inValid,
  input  logic              inTag,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic              outValid,
  output logic [DATA_W-1:0] outData,
  input  logic              outReady,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, READ_SYM, GET_COUNT, EMIT_RUN} state_t;

  state_t            r_state, w_next;
  logic [DATA_W:0]   r_runCnt;
  logic [DATA_W-1:0] r_runChar;
  logic [DATA_W-1:0] r_outData;
  logic              r_outValid;
  logic              r_err;

  logic              w_inReady, w_inXfer, w_outXfer;
  logic [DATA_W:0]   w_count;
  logic              w_bad_lit, w_bad_run, w_err_set;

  assign w_count   = {inTag, inData};
  assign w_inReady = ((r_state == READ_SYM) || (r_state == GET_COUNT)) && (!r_outValid || outReady);
  assign w_inXfer  = inValid && w_inReady;
  assign w_outXfer = r_outValid && outReady;

`ifdef RLD_ERR_CHECK_EN
  localparam logic [DATA_W-1:0] PRINT_MIN = DATA_W'(32);
  assign w_bad_lit = (inData < PRINT_MIN);
  assign w_bad_run = (r_runChar < PRINT_MIN);
  // Header character is judged when the header arrives; the zero count when the count arrives.
  assign w_err_set = w_inXfer && (((r_state == READ_SYM) && w_bad_lit) ||
                                  ((r_state == GET_COUNT) && (w_count == '0)));
`else
  assign w_bad_lit = 1'b0;
  assign w_bad_run = 1'b0;
  assign w_err_set = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = READ_SYM;
      READ_SYM:  if (w_inXfer && inTag) w_next = GET_COUNT;
      GET_COUNT: if (w_inXfer) w_next = ((w_count == '0) || w_bad_run) ? READ_SYM : EMIT_RUN;
      EMIT_RUN:  if (w_outXfer && (r_runCnt == (DATA_W+1)'(1))) w_next = READ_SYM;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_runChar  <= '0;
      r_runCnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_set;
      case (r_state)
        READ_SYM: begin
          if (w_outXfer) r_outValid <= 1'b0;
          if (w_inXfer) begin
            if (inTag) begin
              r_runChar <= inData;
            end else if (!w_bad_lit) begin
              r_outData  <= inData;
              r_outValid <= 1'b1;
            end
          end
        end
        GET_COUNT: begin
          // A previous literal may still be draining while the count arrives.
          if (w_outXfer) r_outValid <= 1'b0;
          if (w_inXfer && (w_count != '0) && !w_bad_run) begin
            r_runCnt   <= w_count;
            r_outData  <= r_runChar;
            r_outValid <= 1'b1;
          end
        end
        EMIT_RUN: begin
          if (w_outXfer) begin
            r_runCnt <= r_runCnt - 1'b1;
            if (r_runCnt == (DATA_W+1)'(1)) r_outValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign inReady  = w_inReady;
  assign outValid = r_outValid;
  assign outData  = r_outData;
  assign err      = r_err;

endmodule
